// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, frame-bit levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  // Even parity over up to 32 bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running CLK_DIV divider with a synchronous restart, one-cycle tick at wrap.
module uart_baud_tick #(
  parameter int CLK_DIV = 54
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic          tick_r;

  // Divider counter and registered tick; restart realigns the phase to the caller's event.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {CW{1'b0}};
      tick_r    <= 1'b0;
    end else if (restart) begin
      div_cnt_r <= {CW{1'b0}};
      tick_r    <= 1'b0;
    end else begin
      tick_r    <= (div_cnt_r == DIV_LAST);
      div_cnt_r <= (div_cnt_r == DIV_LAST) ? {CW{1'b0}} : div_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 54,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int            SW       = $clog2(OVERSAMPLE);
  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta_r;
  logic                 rx_s;
  logic                 rx_d;
  logic                 restart_s;
  logic                 tick_s;
  rx_state_e            state_r;
  logic [SW-1:0]        smp_cnt_r;
  logic [BW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_out_r;
  logic                 data_valid_r;
  logic                 frame_err_r;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_r;
  logic                 parity_err_r;
`endif

  // Two-flop synchroniser plus one history flop for edge detection; idle-high reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
    end else begin
      rx_meta_r <= rx_in;
      rx_s      <= rx_meta_r;
      rx_d      <= rx_s;
    end
  end

  // Only a genuine falling edge starts a frame, so a held break line is ignored.
  assign restart_s = (state_r == IDLE) && (rx_d == STOP_BIT) && (rx_s == START_BIT);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Receive FSM with registered result pulses and busy flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      smp_cnt_r    <= {SW{1'b0}};
      bit_idx_r    <= {BW{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      data_out_r   <= {DATA_BITS{1'b0}};
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (restart_s) begin
            state_r   <= START;
            smp_cnt_r <= {SW{1'b0}};
            busy_r    <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            if (smp_cnt_r == MID_CNT) begin
              smp_cnt_r <= {SW{1'b0}};
              bit_idx_r <= {BW{1'b0}};
              if (rx_s == START_BIT) begin
                state_r <= DATA;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              smp_cnt_r <= smp_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (smp_cnt_r == LAST_CNT) begin
              smp_cnt_r          <= {SW{1'b0}};
              shift_r[bit_idx_r] <= rx_s;
              if (bit_idx_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end else begin
                bit_idx_r <= bit_idx_r + {{(BW-1){1'b0}}, 1'b1};
              end
            end else begin
              smp_cnt_r <= smp_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            if (smp_cnt_r == LAST_CNT) begin
              smp_cnt_r <= {SW{1'b0}};
              par_bad_r <= (rx_s != even_parity(32'(shift_r)));
              state_r   <= STOP;
            end else begin
              smp_cnt_r <= smp_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            if (smp_cnt_r == LAST_CNT) begin
              smp_cnt_r   <= {SW{1'b0}};
              state_r     <= IDLE;
              busy_r      <= 1'b0;
              frame_err_r <= (rx_s != STOP_BIT);
`ifdef UART_RX_PARITY_EN
              parity_err_r <= par_bad_r;
              if ((rx_s == STOP_BIT) && !par_bad_r) begin
`else
              if (rx_s == STOP_BIT) begin
`endif
                data_out_r   <= shift_r;
                data_valid_r <= 1'b1;
              end
            end else begin
              smp_cnt_r <= smp_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLK_DIV=1, OVERSAMPLE=16 (16 sys_clk cycles per bit).
module tb_uart_rx;

  logic       sys_clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_data = 8'h00;

  uart_rx #(.CLK_DIV(1), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle with a result pulse consumes one expectation.
  always @(negedge sys_clk) begin
    if (rst_n && (data_valid || frame_err || parity_err)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got v=%0b fe=%0b pe=%0b data=%0h, expected no pulse",
                 data_valid, frame_err, parity_err, data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_flags", {29'd0, data_valid, frame_err, parity_err}, {29'd0, e.v, e.fe, e.pe});
        check("pulse_data", {24'd0, data_out}, {24'd0, e.d});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge sys_clk);
    rx_in = b;
    repeat (15) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`endif
    send_bit(stop_v);
  endtask

  // Push the expected result of a frame, then send it.
  task automatic frame_expect(input logic [7:0] d, input logic stop_v, input logic par_v);
    exp_t e;
    logic par_ok;
    par_ok = (par_v == ^d);
`ifndef UART_RX_PARITY_EN
    par_ok = 1'b1;
`endif
    e.fe = !stop_v;
    e.pe = !par_ok;
    e.v  = stop_v && par_ok;
    if (e.v) model_data = d;
    e.d = model_data;
    exp_q.push_back(e);
    send_frame(d, stop_v, par_v);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Single frame
    frame_expect(8'hA5, 1'b1, ^8'hA5);
    wait_idle("idle_after_a5");
    check("data_out_a5", {24'd0, data_out}, 32'hA5);

    // Back-to-back frames, no idle gap
    frame_expect(8'h00, 1'b1, ^8'h00);
    frame_expect(8'hFF, 1'b1, ^8'hFF);
    frame_expect(8'h3C, 1'b1, ^8'h3C);
    wait_idle("idle_after_b2b");
    wait_drain();

    // Start glitch: 4 low cycles then high
    @(negedge sys_clk);
    rx_in = 1'b0;
    repeat (4) @(negedge sys_clk);
    rx_in = 1'b1;
    repeat (16) @(negedge sys_clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_data_out", {24'd0, data_out}, 32'h3C);

    // Bad stop bit followed by a held break line
    frame_expect(8'h55, 1'b0, ^8'h55);
    rx_in = 1'b0;
    repeat (40 * 16) @(negedge sys_clk);
    check("break_busy", {31'd0, busy}, 32'd0);
    check("break_data_out", {24'd0, data_out}, 32'h3C);
    rx_in = 1'b1;
    repeat (32) @(negedge sys_clk);
    wait_drain();

    // Reset in the middle of bit 4 of 0x81
    partial = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    @(negedge sys_clk);
    rx_in = partial[4];
    repeat (8) @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    rx_in = 1'b1;
    model_data = 8'h00;
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("post_rst_data_out", {24'd0, data_out}, 32'h0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    frame_expect(8'h7E, 1'b1, ^8'h7E);
    wait_idle("idle_after_7e");
    check("data_out_7e", {24'd0, data_out}, 32'h7E);

`ifdef UART_RX_PARITY_EN
    frame_expect(8'h03, 1'b1, 1'b0);
    frame_expect(8'h03, 1'b1, 1'b1);
    wait_idle("idle_after_parity");
    check("data_out_parity", {24'd0, data_out}, 32'h03);
`endif

    repeat (20) @(negedge sys_clk);
    wait_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
